// File: rtl/cmd_retirer_pkg.sv
// Shared command-retirement types: core/command id widths and the scoreboard flush key.
// Pure definitions, no logic or timing.
package cmd_retirer_pkg;
   localparam int ID_WIDTH     = 2;
   localparam int PROC_COUNT   = 1 << ID_WIDTH;
   localparam int CMD_ID_WIDTH = 8;

   typedef struct packed {
      logic [CMD_ID_WIDTH-1:0] cmd_id;
      logic [ID_WIDTH-1:0]     core_id;
   } entry_t;
endpackage

// File: rtl/retire_fifo.sv
// Synchronous FIFO with full/empty flags; head visible combinationally, push-to-head 1 cycle.
// Push while full is accepted only together with a pop, otherwise ignored.
module retire_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty    = (wr_ptr == rd_ptr);
   assign o_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop     = i_pop && !o_empty;
   assign do_push    = i_push && (!o_full || do_pop);
   assign o_head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_dat;
   end
endmodule

// File: rtl/cmd_retirer.sv
// Retires core completions: round-robin accept, queue, then one scoreboard flush at a time.
// Head-to-flush 1 cycle, response-to-pulse 1 cycle; o_done_ready held low while the queue is full.
module cmd_retirer
   import cmd_retirer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                                   i_clk,
   input  logic                                   i_rstn,
   input  logic [PROC_COUNT-1:0]                  i_done,
   input  logic [PROC_COUNT-1:0][CMD_ID_WIDTH-1:0] i_done_cmd_id,
   output logic [PROC_COUNT-1:0]                  o_done_ready,
   output entry_t                                 o_sb_entry,
   output logic                                   o_sb_flush,
   input  logic                                   i_sb_ack,
   input  logic                                   i_sb_miss,
   output logic                                   o_retired,
   output logic [CMD_ID_WIDTH-1:0]                o_retired_id,
   output logic                                   o_err
);
   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;
   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [ID_WIDTH-1:0]     rr_ptr;
   logic [ID_WIDTH-1:0]     grant_idx;
   logic [ID_WIDTH-1:0]     cand;
   logic                    grant_vld;
   logic                    accept;
   logic [CMD_ID_WIDTH-1:0] grant_cmd_id;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   entry_t                  push_dat;
   entry_t                  head_dat;
   entry_t                  entry_q;
   logic                    illegal_q;
   logic                    done_ok_q;
   logic                    done_ok_nxt;
   logic [TO_W-1:0]         to_cnt;

   // Scan from the highest offset down so the core nearest rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = PROC_COUNT - 1; i >= 0; i--) begin
         cand = rr_ptr + ID_WIDTH'(i);
         if (i_done[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign accept       = grant_vld && !fifo_full && i_rstn;
   assign grant_cmd_id = i_done_cmd_id[grant_idx];
   assign push_dat     = '{cmd_id: grant_cmd_id, core_id: grant_idx};
   assign fifo_push    = accept && (grant_cmd_id != '0);

   always_comb begin
      o_done_ready = '0;
      if (accept) o_done_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rr_ptr    <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && (grant_cmd_id == '0);
         if (accept) rr_ptr <= grant_idx + 1'b1;
      end
   end

   retire_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_push     (fifo_push),
      .i_push_dat (push_dat),
      .i_pop      (fifo_pop),
      .o_head_dat (head_dat),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty)
   );

   always_comb begin
      state_nxt   = state;
      fifo_pop    = 1'b0;
      done_ok_nxt = done_ok_q;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (i_sb_ack) begin
               state_nxt   = S_DONE;
               done_ok_nxt = 1'b1;
            end else if (i_sb_miss || (to_cnt == TO_W'(TIMEOUT - 1))) begin
               state_nxt   = S_DONE;
               done_ok_nxt = 1'b0;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= S_IDLE;
         done_ok_q <= 1'b0;
         entry_q   <= '0;
         to_cnt    <= '0;
      end else begin
         state     <= state_nxt;
         done_ok_q <= done_ok_nxt;
         if (fifo_pop) begin
            entry_q <= head_dat;
            to_cnt  <= '0;
         end else if (state == S_FLUSH) begin
            to_cnt  <= to_cnt + 1'b1;
         end
      end
   end

   // An illegal-id error landing on the S_DONE error cycle simply ORs into one pulse.
   assign o_sb_flush   = (state == S_FLUSH);
   assign o_sb_entry   = entry_q;
   assign o_retired    = (state == S_DONE) && done_ok_q;
   assign o_retired_id = o_retired ? entry_q.cmd_id : '0;
   assign o_err        = ((state == S_DONE) && !done_ok_q) || illegal_q;
endmodule

// File: tb/tb_cmd_retirer.sv
// Directed bench for cmd_retirer: arbitration order, flush/ack/miss/timeout, backpressure, resets.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
module tb_cmd_retirer;
   import cmd_retirer_pkg::*;

   logic                                   clk = 1'b0;
   logic                                   rstn;
   logic [PROC_COUNT-1:0]                  done;
   logic [PROC_COUNT-1:0][CMD_ID_WIDTH-1:0] done_id;
   logic [PROC_COUNT-1:0]                  ready;
   entry_t                                 sb_entry;
   logic                                   sb_flush;
   logic                                   sb_ack;
   logic                                   sb_miss;
   logic                                   retired;
   logic [CMD_ID_WIDTH-1:0]                retired_id;
   logic                                   err;
   int                                     n_cmp = 0;
   int                                     n_bad = 0;

   always #5 clk = ~clk;

   cmd_retirer #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_done        (done),
      .i_done_cmd_id (done_id),
      .o_done_ready  (ready),
      .o_sb_entry    (sb_entry),
      .o_sb_flush    (sb_flush),
      .i_sb_ack      (sb_ack),
      .i_sb_miss     (sb_miss),
      .o_retired     (retired),
      .o_retired_id  (retired_id),
      .o_err         (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rstn = 1'b0; done = '0; done_id = '0; sb_ack = 1'b0; sb_miss = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; done = 4'hF; done_id = {8'd4, 8'd3, 8'd2, 8'd1}; sb_ack = 1'b1; sb_miss = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", ready); end
      n_cmp++; if (sb_flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", sb_flush); end
      n_cmp++; if (retired !== 1'b0) begin n_bad++; $display("FAIL rst_retired: got %b want 0", retired); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
      n_cmp++; if (retired_id !== 8'd0) begin n_bad++; $display("FAIL rst_retired_id: got %0d want 0", retired_id); end
      n_cmp++; if (sb_entry !== 10'd0) begin n_bad++; $display("FAIL rst_entry: got %0h want 0", sb_entry); end
      done = '0; done_id = '0; sb_ack = 1'b0; sb_miss = 1'b0;
      rstn = 1'b1;
      #1;
   endtask

   task automatic test_single();
      done = 4'b0100; done_id[2] = 8'd5; #1;
      n_cmp++; if (ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", ready); end
      step(); done = '0; #1;
      n_cmp++; if (sb_flush !== 1'b0) begin n_bad++; $display("FAIL single_preflush: got %b want 0", sb_flush); end
      step();
      n_cmp++; if (sb_flush !== 1'b1) begin n_bad++; $display("FAIL single_flush: got %b want 1", sb_flush); end
      n_cmp++; if ({sb_entry.cmd_id, sb_entry.core_id} !== {8'd5, 2'd2}) begin
         n_bad++; $display("FAIL single_entry: got id %0d core %0d want id 5 core 2", sb_entry.cmd_id, sb_entry.core_id); end
      step();
      step(); sb_ack = 1'b1; #1;
      n_cmp++; if (retired !== 1'b0) begin n_bad++; $display("FAIL single_early_ret: got %b want 0", retired); end
      step(); sb_ack = 1'b0; #1;
      n_cmp++; if (retired !== 1'b1) begin n_bad++; $display("FAIL single_retired: got %b want 1", retired); end
      n_cmp++; if (retired_id !== 8'd5) begin n_bad++; $display("FAIL single_ret_id: got %0d want 5", retired_id); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
      n_cmp++; if (sb_flush !== 1'b0) begin n_bad++; $display("FAIL single_flush_drop: got %b want 0", sb_flush); end
      step();
      n_cmp++; if (retired !== 1'b0) begin n_bad++; $display("FAIL single_ret_pulse: got %b want 0", retired); end
   endtask

   task automatic test_order();
      logic [7:0] eid   [3];
      logic [1:0] ecore [3];
      eid = '{8'd10, 8'd11, 8'd13};
      ecore = '{2'd0, 2'd1, 2'd3};
      apply_reset();
      done = 4'b1011; done_id[0] = 8'd10; done_id[1] = 8'd11; done_id[3] = 8'd13; #1;
      n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL order_grant0: got %b want 0001", ready); end
      step(); done[0] = 1'b0; #1;
      n_cmp++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL order_grant1: got %b want 0010", ready); end
      step(); done[1] = 1'b0; #1;
      n_cmp++; if (ready !== 4'b1000) begin n_bad++; $display("FAIL order_grant3: got %b want 1000", ready); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({sb_flush, sb_entry.cmd_id, sb_entry.core_id} !== {1'b1, eid[k], ecore[k]}) begin
            n_bad++; $display("FAIL order_flush%0d: got flush %b id %0d core %0d want flush 1 id %0d core %0d",
                              k, sb_flush, sb_entry.cmd_id, sb_entry.core_id, eid[k], ecore[k]); end
         sb_ack = 1'b1;
         step(); done = '0; sb_ack = 1'b0; #1;
         n_cmp++; if ({retired, retired_id} !== {1'b1, eid[k]}) begin
            n_bad++; $display("FAIL order_retire%0d: got %b/%0d want 1/%0d", k, retired, retired_id, eid[k]); end
         step();
         n_cmp++; if (sb_flush !== 1'b0) begin n_bad++; $display("FAIL order_gap%0d: got %b want 0", k, sb_flush); end
         step();
      end
   endtask

   task automatic test_timeout();
      int hi = 0;
      apply_reset();
      done = 4'b0110; done_id[1] = 8'd7; done_id[2] = 8'd8; #1;
      n_cmp++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL to_grant1: got %b want 0010", ready); end
      step(); done = 4'b0100; #1;
      n_cmp++; if (ready !== 4'b0100) begin n_bad++; $display("FAIL to_grant2: got %b want 0100", ready); end
      step(); done = '0; #1;
      n_cmp++; if ({sb_entry.cmd_id, sb_entry.core_id} !== {8'd7, 2'd1}) begin
         n_bad++; $display("FAIL to_entry: got id %0d core %0d want id 7 core 1", sb_entry.cmd_id, sb_entry.core_id); end
      for (int i = 0; i < 16; i++) begin
         if (sb_flush === 1'b1) hi++;
         step();
      end
      n_cmp++; if (hi !== 16) begin n_bad++; $display("FAIL to_flush_len: got %0d cycles want 16", hi); end
      n_cmp++; if ({sb_flush, err, retired} !== 3'b010) begin
         n_bad++; $display("FAIL to_err: got flush/err/ret %b want 010", {sb_flush, err, retired}); end
      step();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", err); end
      step();
      n_cmp++; if ({sb_flush, sb_entry.cmd_id, sb_entry.core_id} !== {1'b1, 8'd8, 2'd2}) begin
         n_bad++; $display("FAIL to_next: got flush %b id %0d core %0d want 1/8/2", sb_flush, sb_entry.cmd_id, sb_entry.core_id); end
      sb_ack = 1'b1;
      step(); sb_ack = 1'b0; #1;
      n_cmp++; if ({retired, retired_id} !== {1'b1, 8'd8}) begin
         n_bad++; $display("FAIL to_next_ret: got %b/%0d want 1/8", retired, retired_id); end
   endtask

   task automatic test_full();
      logic [7:0] eid   [5];
      logic [1:0] ecore [5];
      int lowcnt = 0;
      eid = '{8'd31, 8'd32, 8'd33, 8'd34, 8'd35};
      ecore = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      apply_reset();
      done = 4'b0001; done_id[0] = 8'd20;
      step(); done = '0;
      step();
      n_cmp++; if ({sb_flush, sb_entry.cmd_id} !== {1'b1, 8'd20}) begin
         n_bad++; $display("FAIL full_busy: got flush %b id %0d want 1/20", sb_flush, sb_entry.cmd_id); end
      for (int i = 0; i < 4; i++) begin
         done = '0; done[ecore[i]] = 1'b1; done_id[ecore[i]] = eid[i]; #1;
         n_cmp++; if (ready !== done) begin n_bad++; $display("FAIL full_accept%0d: got %b want %b", i, ready, done); end
         step(); done = '0;
      end
      done = 4'b0010; done_id[1] = 8'd35; #1;
      for (int i = 0; i < 14; i++) begin
         if (ready === 4'b0000) lowcnt++;
         step();
      end
      n_cmp++; if (lowcnt !== 14) begin n_bad++; $display("FAIL full_blocked: got %0d low cycles want 14", lowcnt); end
      n_cmp++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL full_release: got %b want 0010", ready); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if ({sb_flush, sb_entry.cmd_id, sb_entry.core_id} !== {1'b1, eid[k], ecore[k]}) begin
            n_bad++; $display("FAIL full_drain%0d: got flush %b id %0d core %0d want flush 1 id %0d core %0d",
                              k, sb_flush, sb_entry.cmd_id, sb_entry.core_id, eid[k], ecore[k]); end
         sb_ack = 1'b1;
         step(); done = '0; sb_ack = 1'b0; #1;
         n_cmp++; if ({retired, retired_id} !== {1'b1, eid[k]}) begin
            n_bad++; $display("FAIL full_retire%0d: got %b/%0d want 1/%0d", k, retired, retired_id, eid[k]); end
         step(); step();
      end
   endtask

   task automatic test_illegal_and_miss();
      apply_reset();
      done = 4'b0100; done_id[2] = 8'd0; #1;
      n_cmp++; if (ready !== 4'b0100) begin n_bad++; $display("FAIL ill_ready: got %b want 0100", ready); end
      step(); done = '0; #1;
      n_cmp++; if ({err, sb_flush} !== 2'b10) begin n_bad++; $display("FAIL ill_err: got err/flush %b want 10", {err, sb_flush}); end
      step(); sb_ack = 1'b1; #1;
      n_cmp++; if ({err, sb_flush} !== 2'b00) begin n_bad++; $display("FAIL ill_pulse: got err/flush %b want 00", {err, sb_flush}); end
      step(); sb_ack = 1'b0; #1;
      n_cmp++; if ({retired, sb_flush} !== 2'b00) begin n_bad++; $display("FAIL idle_ack: got ret/flush %b want 00", {retired, sb_flush}); end
      done = 4'b1000; done_id[3] = 8'd9;
      step(); done = '0;
      step();
      n_cmp++; if ({sb_flush, sb_entry.cmd_id, sb_entry.core_id} !== {1'b1, 8'd9, 2'd3}) begin
         n_bad++; $display("FAIL miss_flush: got flush %b id %0d core %0d want 1/9/3", sb_flush, sb_entry.cmd_id, sb_entry.core_id); end
      sb_miss = 1'b1;
      step(); sb_miss = 1'b0; #1;
      n_cmp++; if ({err, retired} !== 2'b10) begin n_bad++; $display("FAIL miss_err: got err/ret %b want 10", {err, retired}); end
      step();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL miss_pulse: got %b want 0", err); end
   endtask

   task automatic test_reset_mid_flush();
      int quiet = 0;
      done = 4'b0110; done_id[1] = 8'd40; done_id[2] = 8'd41;
      step(); done = 4'b0100;
      step(); done = '0; #1;
      n_cmp++; if (sb_flush !== 1'b1) begin n_bad++; $display("FAIL mid_flush_up: got %b want 1", sb_flush); end
      rstn = 1'b0; #1;
      n_cmp++; if (sb_flush !== 1'b0) begin n_bad++; $display("FAIL mid_async_drop: got %b want 0", sb_flush); end
      n_cmp++; if (sb_entry !== 10'd0) begin n_bad++; $display("FAIL mid_entry_clr: got %0h want 0", sb_entry); end
      @(posedge clk); #1 rstn = 1'b1; #1;
      for (int i = 0; i < 4; i++) begin
         if (sb_flush === 1'b0 && err === 1'b0) quiet++;
         step();
      end
      n_cmp++; if (quiet !== 4) begin n_bad++; $display("FAIL mid_fifo_empty: got %0d quiet cycles want 4", quiet); end
      done = 4'b1111; done_id = {8'd54, 8'd53, 8'd52, 8'd51}; #1;
      n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", ready); end
      step(); done = '0;
   endtask

   initial begin
      rstn = 1'b0; done = '0; done_id = '0; sb_ack = 1'b0; sb_miss = 1'b0;
      test_reset();
      test_single();
      test_order();
      test_timeout();
      test_full();
      test_illegal_and_miss();
      test_reset_mid_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end
endmodule
